// File: rtl/packed_lane_mac_if.sv
// Operand stream (SD) and result stream (MO) bundle for packed_lane_mac.
// The DUT connects through the slave modport; the operand/result side uses master.
interface packed_lane_mac_if #(
  parameter int unsigned C_DATA_WIDTH = 2,
  parameter int unsigned C_LANES      = 4
);
  localparam int unsigned TDATA_W = 2 * C_DATA_WIDTH * C_LANES;

  logic               SD_AXIS_TREADY;
  logic [TDATA_W-1:0] SD_AXIS_TDATA;
  logic               SD_AXIS_TLAST;
  logic               SD_AXIS_TVALID;
  logic [31:0]        SD_AXIS_TUSER;

  logic               MO_AXIS_TVALID;
  logic [31:0]        MO_AXIS_TDATA;
  logic               MO_AXIS_TLAST;
  logic               MO_AXIS_TREADY;
  logic [7:0]         MO_AXIS_TID;
  logic               MO_AXIS_TUSER;

  modport slave (
    input  SD_AXIS_TDATA, SD_AXIS_TLAST, SD_AXIS_TVALID, SD_AXIS_TUSER, MO_AXIS_TREADY,
    output SD_AXIS_TREADY, MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TLAST, MO_AXIS_TID,
           MO_AXIS_TUSER
  );

  modport master (
    output SD_AXIS_TDATA, SD_AXIS_TLAST, SD_AXIS_TVALID, SD_AXIS_TUSER, MO_AXIS_TREADY,
    input  SD_AXIS_TREADY, MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TLAST, MO_AXIS_TID,
           MO_AXIS_TUSER
  );
endinterface

// File: rtl/packed_lane_mac.sv
// Multi-lane signed MAC: per-packet bias plus sum of lane products, one result per packet.
// Pipeline: lane products -> lane sum -> accumulator -> output register.
module packed_lane_mac #(
  parameter int unsigned C_DATA_WIDTH = 2,
  parameter int unsigned C_LANES      = 4,
  parameter int unsigned C_ACC_WIDTH  = 32,
  parameter int unsigned C_SATURATE   = 0
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  packed_lane_mac_if.slave  axis
);
  localparam int unsigned W  = C_DATA_WIDTH;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = PW + $clog2(C_LANES);
  localparam int unsigned BW = 2 * W * C_LANES;
  localparam int unsigned AW = C_ACC_WIDTH;

  typedef enum logic {ST_BIAS, ST_ACCUM} state_t;

  state_t state, state_nxt;
  logic   en, accept, is_bias;

  logic signed [W-1:0]  lane_a [C_LANES];
  logic signed [W-1:0]  lane_b [C_LANES];
  logic signed [PW-1:0] prod   [C_LANES];
  logic signed [BW-1:0] bias_raw;
  logic signed [AW-1:0] bias_in;

  logic                 s1_valid, s1_bias_flag, s1_last;
  logic [7:0]           s1_tag;
  logic signed [PW-1:0] s1_prod [C_LANES];
  logic signed [AW-1:0] s1_bias;

  logic signed [SW-1:0] lane_sum;
  logic                 s2_valid, s2_bias_flag, s2_last;
  logic [7:0]           s2_tag;
  logic signed [SW-1:0] s2_sum;
  logic signed [AW-1:0] s2_bias;

  logic signed [AW-1:0] sum_ext;
  logic        [AW:0]   add_full;
  logic                 add_ovf;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] acc;
  logic [7:0]           acc_tag;
  logic                 ovf_flag, s3_emit;

  logic                 out_valid, out_user;
  logic [31:0]          out_data;
  logic [7:0]           out_tid;
  logic                 unused_tuser;

  assign unused_tuser = ^axis.SD_AXIS_TUSER[31:8];

  // Everything freezes while a result is waiting on a stalled consumer.
  assign en                  = !(out_valid && !axis.MO_AXIS_TREADY);
  assign axis.SD_AXIS_TREADY = en && ARESETN;
  assign accept              = axis.SD_AXIS_TVALID && axis.SD_AXIS_TREADY;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= ST_BIAS;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    is_bias   = (state == ST_BIAS);
    if (accept) begin
      case (state)
        ST_BIAS:  state_nxt = axis.SD_AXIS_TLAST ? ST_BIAS : ST_ACCUM;
        ST_ACCUM: state_nxt = axis.SD_AXIS_TLAST ? ST_BIAS : ST_ACCUM;
        default:  state_nxt = ST_BIAS;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < C_LANES; i++) begin
      lane_a[i] = axis.SD_AXIS_TDATA[(2*i+1)*W +: W];
      lane_b[i] = axis.SD_AXIS_TDATA[(2*i)*W +: W];
      prod[i]   = PW'(lane_a[i]) * PW'(lane_b[i]);
    end
    bias_raw = axis.SD_AXIS_TDATA;
    bias_in  = AW'(bias_raw);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      s1_valid     <= 1'b0;
      s1_bias_flag <= 1'b0;
      s1_last      <= 1'b0;
      s1_tag       <= '0;
      s1_bias      <= '0;
      for (int unsigned i = 0; i < C_LANES; i++) s1_prod[i] <= '0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_bias_flag <= is_bias;
        s1_last      <= axis.SD_AXIS_TLAST;
        s1_tag       <= axis.SD_AXIS_TUSER[7:0];
        s1_bias      <= bias_in;
        for (int unsigned i = 0; i < C_LANES; i++) s1_prod[i] <= prod[i];
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < C_LANES; i++) lane_sum = lane_sum + SW'(s1_prod[i]);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      s2_valid     <= 1'b0;
      s2_bias_flag <= 1'b0;
      s2_last      <= 1'b0;
      s2_tag       <= '0;
      s2_sum       <= '0;
      s2_bias      <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bias_flag <= s1_bias_flag;
        s2_last      <= s1_last;
        s2_tag       <= s1_tag;
        s2_sum       <= lane_sum;
        s2_bias      <= s1_bias;
      end
    end
  end

  // One guard bit on the add exposes both overflow and the true sign for clamping.
  always_comb begin
    sum_ext  = AW'(s2_sum);
    add_full = {acc[AW-1], acc} + {sum_ext[AW-1], sum_ext};
    add_ovf  = add_full[AW] != add_full[AW-1];
    acc_nxt  = add_full[AW-1:0];
    if (add_ovf && (C_SATURATE != 0))
      acc_nxt = add_full[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      acc      <= '0;
      acc_tag  <= '0;
      ovf_flag <= 1'b0;
      s3_emit  <= 1'b0;
    end else if (en) begin
      s3_emit <= s2_valid && s2_last;
      if (s2_valid) begin
        if (s2_bias_flag) begin
          acc      <= s2_bias;
          acc_tag  <= s2_tag;
          ovf_flag <= 1'b0;
        end else begin
          acc      <= acc_nxt;
          ovf_flag <= ovf_flag | add_ovf;
        end
      end
    end
  end

  // The next packet's bias may overwrite acc on the same edge this captures the old value.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tid   <= '0;
      out_user  <= 1'b0;
    end else if (en) begin
      if (s3_emit) begin
        out_valid <= 1'b1;
        out_data  <= 32'(acc);
        out_tid   <= acc_tag;
        out_user  <= ovf_flag;
      end else begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_tid   <= '0;
        out_user  <= 1'b0;
      end
    end
  end

  assign axis.MO_AXIS_TVALID = out_valid;
  assign axis.MO_AXIS_TDATA  = out_data;
  assign axis.MO_AXIS_TLAST  = out_valid;
  assign axis.MO_AXIS_TID    = out_tid;
  assign axis.MO_AXIS_TUSER  = out_user;
endmodule
